// File: rtl/sort_pkg.sv
// Types and default sizes shared by the sort pipeline blocks.
package sort_pkg;

  localparam int SORT_VALUE_BITS = 8;
  localparam int SORT_DEPTH      = 5;
  localparam int SORT_SIZE       = 1 << SORT_DEPTH;

  typedef logic [SORT_VALUE_BITS-1:0] value_t;
  typedef logic [SORT_SIZE-1:0][SORT_VALUE_BITS-1:0] vec_t;

  // Index counters need at least one bit, even for single-element vectors.
  function automatic int idx_width(input int depth);
    return (depth > 0) ? depth : 1;
  endfunction

endpackage

// File: rtl/sort_vec_slot.sv
// One vector-wide storage slot: parallel load of a packed vector, element read by index.
module sort_vec_slot
  import sort_pkg::*;
#(
  parameter int VALUE_BITS = SORT_VALUE_BITS,
  parameter int SIZE       = SORT_SIZE,
  parameter int IDX_W      = idx_width(SORT_DEPTH)
) (
  input  logic                       clk,
  input  logic                       load,
  input  logic [SIZE*VALUE_BITS-1:0] din,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [VALUE_BITS-1:0]      rd_data
);

  logic [VALUE_BITS-1:0] mem_reg [SIZE];

  // Capture the whole vector at once; data needs no reset since validity lives in the full bits.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < SIZE; i++) begin
        mem_reg[i] <= din[i*VALUE_BITS +: VALUE_BITS];
      end
    end
  end

  // Element select for the drain side.
  always_comb begin
    rd_data = mem_reg[rd_idx];
  end

endmodule

// File: rtl/sorted_vector_serializer.sv
// Ping-pong buffered serializer: captures sorted vectors whole, streams elements one per cycle.
module sorted_vector_serializer
  import sort_pkg::*;
#(
  parameter int VALUE_BITS = SORT_VALUE_BITS,
  parameter int DEPTH      = SORT_DEPTH,
  parameter int SIZE       = 1 << DEPTH,
  parameter int REVERSE    = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       vec_valid,
  output logic                       vec_ready,
  input  logic [SIZE*VALUE_BITS-1:0] vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [VALUE_BITS-1:0]      out_data,
  output logic                       out_last,
  output logic                       overflow
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  logic [1:0]       full_reg, full_next;
  logic             wr_sel_reg, wr_sel_next;
  logic             rd_sel_reg, rd_sel_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             overflow_reg, overflow_next;

  logic             capture;
  logic             drain;
  logic [IDX_W-1:0] phys_idx;
  logic [VALUE_BITS-1:0] slot_data [2];

  // Handshake decode; vec_ready looks only at registered full bits, so a slot freed this
  // cycle becomes writable on the next one.
  always_comb begin
    vec_ready = ~full_reg[wr_sel_reg];
    out_valid = full_reg[rd_sel_reg];
    capture   = vec_valid & vec_ready;
    drain     = out_valid & out_ready;
    phys_idx  = (REVERSE != 0) ? (LAST_IDX - idx_reg) : idx_reg;
    out_last  = out_valid & (idx_reg == LAST_IDX);
    out_data  = out_valid ? slot_data[rd_sel_reg] : '0;
    overflow  = overflow_reg;
  end

  // Two identical slots; slot gi loads when it is the capture target.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      sort_vec_slot #(
        .VALUE_BITS (VALUE_BITS),
        .SIZE       (SIZE),
        .IDX_W      (IDX_W)
      ) u_slot (
        .clk     (clk),
        .load    (capture & (wr_sel_reg == 1'(gi))),
        .din     (vec),
        .rd_idx  (phys_idx),
        .rd_data (slot_data[gi])
      );
    end
  endgenerate

  // Next-state for slot bookkeeping; capture and final-element drain touch different slots.
  always_comb begin
    full_next     = full_reg;
    wr_sel_next   = wr_sel_reg;
    rd_sel_next   = rd_sel_reg;
    idx_next      = idx_reg;
    overflow_next = overflow_reg | (vec_valid & ~vec_ready);

    if (drain) begin
      if (idx_reg == LAST_IDX) begin
        idx_next              = '0;
        full_next[rd_sel_reg] = 1'b0;
        rd_sel_next           = ~rd_sel_reg;
      end else begin
        idx_next = idx_reg + 1'b1;
      end
    end

    if (capture) begin
      full_next[wr_sel_reg] = 1'b1;
      wr_sel_next           = ~wr_sel_reg;
    end
  end

  // Control state registers; reset empties both slots and clears the sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_reg     <= 2'b00;
      wr_sel_reg   <= 1'b0;
      rd_sel_reg   <= 1'b0;
      idx_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      full_reg     <= full_next;
      wr_sel_reg   <= wr_sel_next;
      rd_sel_reg   <= rd_sel_next;
      idx_reg      <= idx_next;
      overflow_reg <= overflow_next;
    end
  end

endmodule

// File: tb/tb_sorted_vector_serializer.sv
// Bench: two DEPTH=2 instances (forward and reversed) driven identically, checked against a
// queue-of-vectors reference model every cycle plus directed end-of-test checks.
module tb_sorted_vector_serializer;

  localparam int VB    = 8;
  localparam int DEPTH = 2;
  localparam int SIZE  = 1 << DEPTH;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 vec_valid;
  logic [SIZE*VB-1:0]   vec;
  logic                 out_ready;

  logic                 vec_ready_f, out_valid_f, out_last_f, overflow_f;
  logic [VB-1:0]        out_data_f;
  logic                 vec_ready_r, out_valid_r, out_last_r, overflow_r;
  logic [VB-1:0]        out_data_r;

  always #5 clk = ~clk;

  sorted_vector_serializer #(.VALUE_BITS(VB), .DEPTH(DEPTH), .REVERSE(0)) dut_f (
    .clk       (clk),
    .rst_n     (rst_n),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready_f),
    .vec       (vec),
    .out_valid (out_valid_f),
    .out_ready (out_ready),
    .out_data  (out_data_f),
    .out_last  (out_last_f),
    .overflow  (overflow_f)
  );

  sorted_vector_serializer #(.VALUE_BITS(VB), .DEPTH(DEPTH), .REVERSE(1)) dut_r (
    .clk       (clk),
    .rst_n     (rst_n),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready_r),
    .vec       (vec),
    .out_valid (out_valid_r),
    .out_ready (out_ready),
    .out_data  (out_data_r),
    .out_last  (out_last_r),
    .overflow  (overflow_r)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: FIFO of accepted vectors (at most two), position within the head vector.
  logic [SIZE*VB-1:0] vq[$];
  int                 pos = 0;
  logic               ovf = 1'b0;
  logic               accepted_now = 1'b0;
  int                 n_accepted = 0;
  logic [VB-1:0]      exp_stream[$];
  logic [VB-1:0]      obs_f[$];
  logic [VB-1:0]      obs_r[$];

  // Stall-stability tracking for the forward instance.
  logic               prev_hold = 1'b0;
  logic [VB-1:0]      prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VB-1:0] elem(input logic [SIZE*VB-1:0] v, input int i);
    return v[i*VB +: VB];
  endfunction

  task automatic check_outputs();
    logic          e_valid;
    logic          e_ready;
    logic [VB-1:0] e_data_f, e_data_r;
    logic          e_last;
    e_valid  = (vq.size() > 0);
    e_ready  = (vq.size() < 2);
    e_data_f = e_valid ? elem(vq[0], pos) : '0;
    e_data_r = e_valid ? elem(vq[0], SIZE - 1 - pos) : '0;
    e_last   = e_valid && (pos == SIZE - 1);
    check("vec_ready_f", 32'(vec_ready_f), 32'(e_ready));
    check("out_valid_f", 32'(out_valid_f), 32'(e_valid));
    check("out_data_f",  32'(out_data_f),  32'(e_data_f));
    check("out_last_f",  32'(out_last_f),  32'(e_last));
    check("overflow_f",  32'(overflow_f),  32'(ovf));
    check("vec_ready_r", 32'(vec_ready_r), 32'(e_ready));
    check("out_valid_r", 32'(out_valid_r), 32'(e_valid));
    check("out_data_r",  32'(out_data_r),  32'(e_data_r));
    check("out_last_r",  32'(out_last_r),  32'(e_last));
    check("overflow_r",  32'(overflow_r),  32'(ovf));
    if (prev_hold) begin
      check("stall_valid", 32'(out_valid_f), 32'd1);
      check("stall_data",  32'(out_data_f),  32'(prev_data));
    end
    prev_hold = out_valid_f && !out_ready;
    prev_data = out_data_f;
    if (out_valid_f && out_ready) obs_f.push_back(out_data_f);
    if (out_valid_r && out_ready) obs_r.push_back(out_data_r);
  endtask

  task automatic model_edge();
    logic rdy, val;
    accepted_now = 1'b0;
    if (!rst_n) begin
      vq.delete();
      pos       = 0;
      ovf       = 1'b0;
      prev_hold = 1'b0;
    end else begin
      rdy = (vq.size() < 2);
      val = (vq.size() > 0);
      if (val && out_ready) begin
        if (pos == SIZE - 1) begin
          void'(vq.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (vec_valid) begin
        if (rdy) begin
          vq.push_back(vec);
          for (int i = 0; i < SIZE; i++) exp_stream.push_back(elem(vec, i));
          accepted_now = 1'b1;
          n_accepted++;
          $display("[TB] capture vec=%h", vec);
        end else begin
          ovf = 1'b1;
          $display("[TB] dropped vec=%h (no free slot)", vec);
        end
      end
    end
  endtask

  task automatic cyc();
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drain_all();
    int guard;
    guard = 0;
    out_ready = 1'b1;
    vec_valid = 1'b0;
    while (vq.size() > 0 && guard < 50) begin
      cyc();
      guard++;
    end
    check("drain_timeout", 32'(vq.size()), 32'd0);
  endtask

  initial begin
    int wait_cycles;
    int cycles;
    logic [SIZE*VB-1:0] v;

    rst_n = 1'b0; vec_valid = 1'b0; vec = '0; out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); model_edge(); #1;
    end
    rst_n = 1'b1;

    // Reset state
    check("rst_vec_ready", 32'(vec_ready_f), 32'd1);
    check("rst_out_valid", 32'(out_valid_f), 32'd0);
    check("rst_out_data",  32'(out_data_f),  32'd0);
    check("rst_out_last",  32'(out_last_f),  32'd0);
    check("rst_overflow",  32'(overflow_f),  32'd0);

    // Single vector {4,3,2,1}: forward 1,2,3,4 and reversed 4,3,2,1
    obs_f.delete(); obs_r.delete();
    vec = {8'd4, 8'd3, 8'd2, 8'd1};
    vec_valid = 1'b1;
    cyc();
    vec_valid = 1'b0;
    repeat (6) cyc();
    check("t1_count", 32'(obs_f.size()), 32'd4);
    check("t2_count", 32'(obs_r.size()), 32'd4);
    if (obs_f.size() == 4 && obs_r.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t1_seq", 32'(obs_f[i]), 32'(i + 1));
        check("t2_seq", 32'(obs_r[i]), 32'(4 - i));
      end
    end

    // Two back-to-back vectors, third held until a slot frees
    vec = {8'h14, 8'h13, 8'h12, 8'h11}; vec_valid = 1'b1; cyc();
    vec = {8'h24, 8'h23, 8'h22, 8'h21}; cyc();
    vec = {8'h34, 8'h33, 8'h32, 8'h31};
    wait_cycles = 0;
    while (wait_cycles < 20) begin
      cyc();
      wait_cycles++;
      if (accepted_now) break;
    end
    vec_valid = 1'b0;
    check("t3_third_accept_cycles", 32'(wait_cycles), 32'd4);
    check("t3_overflow_set", 32'(overflow_f), 32'd1);
    drain_all();

    // Both slots full under stall, dropped vector leaves contents intact
    obs_f.delete();
    out_ready = 1'b0;
    vec = {8'h44, 8'h43, 8'h42, 8'h41}; vec_valid = 1'b1; cyc();
    vec = {8'h54, 8'h53, 8'h52, 8'h51}; cyc();
    check("t4_vec_ready_low", 32'(vec_ready_f), 32'd0);
    vec = {8'hEE, 8'hEE, 8'hEE, 8'hEE}; cyc();
    vec_valid = 1'b0;
    repeat (3) cyc();
    check("t4_overflow_sticky", 32'(overflow_f), 32'd1);
    drain_all();
    check("t4_count", 32'(obs_f.size()), 32'd8);
    if (obs_f.size() == 8) begin
      check("t4_first",  32'(obs_f[0]), 32'h41);
      check("t4_fourth", 32'(obs_f[3]), 32'h44);
      check("t4_fifth",  32'(obs_f[4]), 32'h51);
      check("t4_last",   32'(obs_f[7]), 32'h54);
    end

    // Randomized traffic, 100 vectors, random backpressure
    obs_f.delete(); exp_stream.delete();
    n_accepted = 0;
    cycles = 0;
    while (n_accepted < 100 && cycles < 4000) begin
      out_ready = ($urandom_range(0, 2) != 0);
      vec_valid = (vq.size() < 2) && ($urandom_range(0, 3) != 0);
      vec = SIZE*VB'($urandom);
      cyc();
      cycles++;
    end
    check("t5_accepted", 32'(n_accepted), 32'd100);
    drain_all();
    check("t5_stream_len", 32'(obs_f.size()), 32'(exp_stream.size()));
    if (obs_f.size() == exp_stream.size()) begin
      for (int i = 0; i < obs_f.size(); i++) check("t5_stream", 32'(obs_f[i]), 32'(exp_stream[i]));
    end

    // Reset in the middle of a vector
    vec = {8'h64, 8'h63, 8'h62, 8'h61}; vec_valid = 1'b1; out_ready = 1'b1; cyc();
    vec_valid = 1'b0;
    cyc(); cyc();
    check("t6_pos_before_rst", 32'(out_data_f), 32'h63);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("t6_out_valid", 32'(out_valid_f), 32'd0);
    check("t6_vec_ready", 32'(vec_ready_f), 32'd1);
    check("t6_overflow",  32'(overflow_f),  32'd0);
    obs_f.delete();
    v = {8'h74, 8'h73, 8'h72, 8'h71};
    vec = v; vec_valid = 1'b1; cyc();
    vec_valid = 1'b0;
    drain_all();
    repeat (2) cyc();
    check("t6_count", 32'(obs_f.size()), 32'd4);
    if (obs_f.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t6_seq", 32'(obs_f[i]), 32'(elem(v, i)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
